// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: UART host-link sequencer that loads A/B operands, starts the multiplier and streams results back.
module matmul_seq_ctrl #(
  parameter int MAX_N       = 8,
  parameter int IDX_W       = 6,
  parameter int RES_W       = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_enable,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [IDX_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [3:0]       mat_n,
  output logic             mult_start,
  input  logic             mult_done,
  output logic [IDX_W-1:0] res_addr,
  input  logic [RES_W-1:0] res_data,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             err_size,
  output logic             err_timeout
);
  localparam int NB = RES_W / 8;
  localparam int BW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, COMPUTE, RD, TX_WAIT, TX_GAP} state_t;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] tcnt;
  logic [RES_W-1:0] sh;
  logic ld;
  logic [7:0] nn_m1;
  logic last, loading;
  assign nn_m1 = {4'd0, mat_n} * {4'd0, mat_n} - 8'd1;
  assign last = 8'(idx) == nn_m1;
  assign loading = state == LOAD_A || state == LOAD_B;
  assign wr_en = loading && rx_valid;
  assign wr_sel = state == LOAD_B;
  assign wr_addr = idx;
  assign wr_data = wr_en ? rx_data : 8'd0;
  assign rx_enable = state == IDLE || loading;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      byte_cnt <= '0;
      tcnt <= '0;
      sh <= '0;
      ld <= 1'b0;
      mat_n <= 4'd0;
      mult_start <= 1'b0;
      res_addr <= '0;
      tx_start <= 1'b0;
      tx_data <= 8'd0;
      err_size <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      tx_start <= 1'b0;
      err_size <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          if (rx_data != 8'd0 && rx_data <= 8'(MAX_N)) begin
            mat_n <= rx_data[3:0];
            idx <= '0;
            tcnt <= '0;
            state <= LOAD_A;
          end else err_size <= 1'b1;
        end
        LOAD_A, LOAD_B: if (rx_valid) begin
          tcnt <= '0;
          if (last) begin
            idx <= '0;
            mult_start <= state == LOAD_B;
            state <= (state == LOAD_A) ? LOAD_B : START;
          end else idx <= idx + 1'b1;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          err_timeout <= 1'b1;
          idx <= '0;
          tcnt <= '0;
          state <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        START: state <= COMPUTE;
        COMPUTE: if (mult_done) begin
          idx <= '0;
          res_addr <= '0;
          byte_cnt <= '0;
          state <= RD;
        end
        RD: begin
          ld <= 1'b1;
          state <= TX_WAIT;
        end
        // first TX_WAIT cycle captures the synchronous-read result word
        TX_WAIT: if (ld) begin
          sh <= res_data;
          ld <= 1'b0;
        end else if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data <= sh[RES_W-1 -: 8];
          state <= TX_GAP;
        end
        TX_GAP: if (byte_cnt < BW'(NB - 1)) begin
          byte_cnt <= byte_cnt + 1'b1;
          sh <= sh << 8;
          state <= TX_WAIT;
        end else if (!last) begin
          idx <= idx + 1'b1;
          res_addr <= idx + 1'b1;
          byte_cnt <= '0;
          state <= RD;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed self-checking bench for the matmul host-link sequencer.
module tb_matmul_seq_ctrl;
  localparam int TO = 40;
  logic clk = 0, rst = 1, rx_valid = 0, mult_done = 0, hold = 0;
  logic [7:0] rx_data = 0;
  logic [15:0] res_data = 0;
  logic rx_enable, wr_en, wr_sel, mult_start, tx_start, busy, err_size, err_timeout, tx_busy;
  logic [5:0] wr_addr, res_addr;
  logic [7:0] wr_data, tx_data;
  logic [3:0] mat_n;
  logic [39:0] outs;
  logic [15:0] res_mem [0:63];
  logic [7:0] tx_q [$];
  int tb_cnt = 0, tx_len = 3;
  int n_wr = 0, n_ms = 0, n_es = 0, n_et = 0, n_tx = 0, n_txbad = 0;
  int checks = 0, failures = 0;

  matmul_seq_ctrl #(.MAX_N(8), .IDX_W(6), .RES_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_enable(rx_enable),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .mat_n(mat_n),
    .mult_start(mult_start), .mult_done(mult_done), .res_addr(res_addr), .res_data(res_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .err_size(err_size), .err_timeout(err_timeout));

  always #5 clk = ~clk;
  assign outs = {rx_enable, wr_en, wr_sel, wr_addr, wr_data, mat_n, mult_start, res_addr,
                 tx_start, tx_data, busy, err_size, err_timeout};
  assign tx_busy = (tb_cnt != 0) || hold;
  always @(posedge clk) res_data <= res_mem[res_addr];
  always @(posedge clk) begin
    if (tx_start) tb_cnt <= tx_len;
    else if (tb_cnt > 0) tb_cnt <= tb_cnt - 1;
  end
  always @(posedge clk) begin
    if (wr_en) n_wr <= n_wr + 1;
    if (mult_start) n_ms <= n_ms + 1;
    if (err_size) n_es <= n_es + 1;
    if (err_timeout) n_et <= n_et + 1;
    if (tx_start) begin
      n_tx <= n_tx + 1;
      tx_q.push_back(tx_data);
      if (tx_busy) n_txbad <= n_txbad + 1;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic load_job(input int n);
    send(8'(n));
    for (int i = 0; i < n * n; i++) send(8'(i + 1));
    for (int i = 0; i < n * n; i++) send(8'(8'h10 + i));
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    ok = !busy;
  endtask

  task automatic test_reset;
    checks++;
    if (outs !== 40'h80_0000_0000) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=%h", outs, 40'h80_0000_0000);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (outs !== 40'h80_0000_0000) begin
      failures++;
      $display("FAIL post_reset_idle got=%h exp=%h", outs, 40'h80_0000_0000);
    end
  endtask

  task automatic test_load;
    int ms0 = n_ms, tx0 = n_tx, qb = tx_q.size();
    bit ok;
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) res_mem[i] = 16'hA1B2 + 16'(i * 16'h0101);
    tx_len = 3;
    send(8'd2);
    checks++;
    if (mat_n !== 4'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_size mat_n=%0d busy=%b exp mat_n=2 busy=1", mat_n, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1;
      rx_data = 8'(i + 1);
      #1;
      exp = {1'b1, 1'(i >= 4), 6'(i % 4), 8'(i + 1)};
      checks++;
      if ({wr_en, wr_sel, wr_addr, wr_data} !== exp) begin
        failures++;
        $display("FAIL load_wr%0d got=%h exp=%h", i, {wr_en, wr_sel, wr_addr, wr_data}, exp);
      end
      @(negedge clk);
      rx_valid = 0;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_ms - ms0 !== 1 || busy !== 1'b1 || n_tx - tx0 !== 0) begin
      failures++;
      $display("FAIL load_compute starts=%0d busy=%b tx=%0d exp 1 1 0", n_ms - ms0, busy, n_tx - tx0);
    end
    @(negedge clk);
    mult_done = 1;
    @(negedge clk);
    mult_done = 0;
    wait_idle(1000, ok);
    checks++;
    if (!ok || n_tx - tx0 !== 8) begin
      failures++;
      $display("FAIL load_tx_count got=%0d exp=8 idle=%b", n_tx - tx0, ok);
    end
    for (int j = 0; j < 8 && qb + j < tx_q.size(); j++) begin
      exp = res_mem[j / 2];
      checks++;
      if (tx_q[qb + j] !== ((j % 2 == 0) ? exp[15:8] : exp[7:0])) begin
        failures++;
        $display("FAIL load_tx_byte%0d got=%h exp=%h", j, tx_q[qb + j], (j % 2 == 0) ? exp[15:8] : exp[7:0]);
      end
    end
  endtask

  task automatic test_size_err;
    int es0 = n_es, wr0 = n_wr;
    send(8'd0);
    send(8'd9);
    repeat (2) @(negedge clk);
    checks++;
    if (n_es - es0 !== 2 || n_wr - wr0 !== 0 || busy !== 1'b0 || mat_n !== 4'd2) begin
      failures++;
      $display("FAIL size_err errs=%0d wr=%0d busy=%b mat_n=%0d exp 2 0 0 2",
               n_es - es0, n_wr - wr0, busy, mat_n);
    end
  endtask

  task automatic test_timeout;
    int et0 = n_et;
    send(8'd3);
    for (int i = 0; i < 4; i++) send(8'(i + 7));
    repeat (38) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || n_et - et0 !== 0) begin
      failures++;
      $display("FAIL timeout_early busy=%b errs=%0d exp 1 0", busy, n_et - et0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mat_n !== 4'd3) begin
      failures++;
      $display("FAIL timeout_idle busy=%b mat_n=%0d exp 0 3", busy, mat_n);
    end
    @(negedge clk);
    checks++;
    if (n_et - et0 !== 1) begin
      failures++;
      $display("FAIL timeout_pulse got=%0d exp=1", n_et - et0);
    end
    send(8'd2);
    checks++;
    if (mat_n !== 4'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_resize mat_n=%0d busy=%b exp 2 1", mat_n, busy);
    end
    repeat (TO + 5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_et - et0 !== 2) begin
      failures++;
      $display("FAIL timeout_second busy=%b errs=%0d exp 0 2", busy, n_et - et0);
    end
  endtask

  task automatic test_single;
    int tx0 = n_tx, ms0 = n_ms, bad0 = n_txbad, qb = tx_q.size();
    bit ok;
    res_mem[0] = 16'h1234;
    tx_len = 10;
    mult_done = 1;
    load_job(1);
    wait_idle(500, ok);
    mult_done = 0;
    checks++;
    if (!ok || n_tx - tx0 !== 2 || n_ms - ms0 !== 1 || n_txbad - bad0 !== 0) begin
      failures++;
      $display("FAIL single_counts idle=%b tx=%0d starts=%0d bad=%0d exp 1 2 1 0",
               ok, n_tx - tx0, n_ms - ms0, n_txbad - bad0);
    end else begin
      checks++;
      if ({tx_q[qb], tx_q[qb + 1]} !== 16'h1234) begin
        failures++;
        $display("FAIL single_bytes got=%h exp=1234", {tx_q[qb], tx_q[qb + 1]});
      end
    end
  endtask

  task automatic test_back_to_back;
    int tx0 = n_tx, bad0 = n_txbad, qb = tx_q.size();
    bit ok;
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) res_mem[i] = 16'hC0D0 + 16'(i * 16'h0111);
    tx_len = 50;
    hold = 1;
    mult_done = 1;
    load_job(2);
    repeat (50) @(negedge clk);
    hold = 0;
    wait_idle(3000, ok);
    mult_done = 0;
    checks++;
    if (!ok || n_tx - tx0 !== 8 || n_txbad - bad0 !== 0) begin
      failures++;
      $display("FAIL busy_hold idle=%b tx=%0d bad=%0d exp 1 8 0", ok, n_tx - tx0, n_txbad - bad0);
    end
    for (int j = 0; j < 8 && qb + j < tx_q.size(); j++) begin
      exp = res_mem[j / 2];
      checks++;
      if (tx_q[qb + j] !== ((j % 2 == 0) ? exp[15:8] : exp[7:0])) begin
        failures++;
        $display("FAIL busy_hold_byte%0d got=%h exp=%h", j, tx_q[qb + j], (j % 2 == 0) ? exp[15:8] : exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int tx0, qb;
    bit ok;
    logic [15:0] exp;
    tx_len = 2;
    send(8'd2);
    for (int i = 0; i < 5; i++) send(8'(i + 1));
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (outs !== 40'h80_0000_0000) begin
      failures++;
      $display("FAIL rst_loadb got=%h exp=%h", outs, 40'h80_0000_0000);
    end
    @(negedge clk);
    rst = 0;
    hold = 1;
    mult_done = 1;
    load_job(2);
    repeat (10) @(negedge clk);
    tx0 = n_tx;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_txwait_pre busy=%b exp=1", busy);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (outs !== 40'h80_0000_0000) begin
      failures++;
      $display("FAIL rst_txwait got=%h exp=%h", outs, 40'h80_0000_0000);
    end
    @(negedge clk);
    rst = 0;
    hold = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (n_tx - tx0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_tx tx=%0d busy=%b exp 0 0", n_tx - tx0, busy);
    end
    for (int i = 0; i < 4; i++) res_mem[i] = 16'h5A00 + 16'(i * 16'h0203);
    tx0 = n_tx;
    qb = tx_q.size();
    load_job(2);
    wait_idle(1000, ok);
    mult_done = 0;
    checks++;
    if (!ok || n_tx - tx0 !== 8) begin
      failures++;
      $display("FAIL rst_fresh_count idle=%b tx=%0d exp 1 8", ok, n_tx - tx0);
    end
    for (int j = 0; j < 8 && qb + j < tx_q.size(); j++) begin
      exp = res_mem[j / 2];
      checks++;
      if (tx_q[qb + j] !== ((j % 2 == 0) ? exp[15:8] : exp[7:0])) begin
        failures++;
        $display("FAIL rst_fresh_byte%0d got=%h exp=%h", j, tx_q[qb + j], (j % 2 == 0) ? exp[15:8] : exp[7:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) res_mem[i] = 16'h0;
    repeat (3) @(negedge clk);
    test_reset;
    test_load;
    test_size_err;
    test_timeout;
    test_single;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Parametrised host-link sequencer for the matrix-multiply engine. It parses a UART byte stream containing a size byte followed by the elements of matrix A and then matrix B, and writes those elements into the operand buffers. It then starts the multiplier, waits for completion and streams the N*N results back over UART as multi-byte words. It adds size validation, an inter-byte receive timeout and multi-byte result serialisation.

Parameters:
MAX_N, 8, largest supported matrix dimension (2..15)
IDX_W, 6, element index width; must satisfy 2^IDX_W >= MAX_N*MAX_N
RES_W, 16, result element width; multiple of 8
TIMEOUT_CYC, 100000, idle clk cycles allowed between received bytes during operand load (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
rx_enable  out  1  receiver enabled
wr_en  out  1  operand buffer write strobe
wr_sel  out  1  0 = matrix A, 1 = matrix B
wr_addr  out  IDX_W  row-major element index
wr_data  out  8  element value
mat_n  out  4  latched dimension N
mult_start  out  1  one-cycle multiplier start pulse
mult_done  in  1  multiplier finished (level or pulse)
res_addr  out  IDX_W  result buffer read index
res_data  in  RES_W  result word, valid 1 cycle after res_addr changes
tx_busy  in  1  UART TX busy; rises by the cycle after tx_start
tx_start  out  1  one-cycle TX start pulse
tx_data  out  8  byte to transmit
busy  out  1  high whenever state != IDLE
err_size  out  1  one-cycle pulse: illegal size byte
err_timeout  out  1  one-cycle pulse: receive timeout

Behaviour:
- Reset: state IDLE; rx_enable=1; every other output 0, including mat_n, indices and counters.
- States: IDLE, LOAD_A, LOAD_B, START, COMPUTE, RD, TX_WAIT, TX_GAP.
- IDLE: on rx_valid, byte N is checked. If 1 <= N <= MAX_N, latch mat_n=N, set idx=0 and go to LOAD_A. Otherwise pulse err_size and stay in IDLE.
- LOAD_A/LOAD_B: each rx_valid produces wr_en=1 in that same cycle, combinationally from rx_valid. In that cycle wr_sel=0/1, wr_addr=idx, wr_data=rx_data.
  - idx increments on each write.
  - When idx == N*N-1 and a write occurs, clear idx and advance: LOAD_A -> LOAD_B, LOAD_B -> START.
  - N*N is computed at 8-bit width.
- Timeout: a counter clears on every rx_valid and on entry to LOAD_A. If it reaches TIMEOUT_CYC while in LOAD_A or LOAD_B, pulse err_timeout, return to IDLE, clear idx and leave mat_n unchanged.
- rx_enable=1 only in IDLE, LOAD_A and LOAD_B. rx_valid in any other state is ignored: no write, no error.
- START: mult_start=1 for exactly one cycle, then go to COMPUTE.
- COMPUTE: wait for mult_done=1, then clear idx, set byte_cnt=0 and go to RD.
  - mult_done is ignored in all other states.
  - mult_done seen in the same cycle as entry to COMPUTE counts as done.
- RD: res_addr=idx. After one cycle go to TX_WAIT; res_data is then registered into a shift register.
- TX_WAIT: when tx_busy=0, assert tx_start for one cycle with tx_data = the current most-significant byte of the shift register (MSB first), then go to TX_GAP.
- TX_GAP: one cycle to let tx_busy rise. Then:
  - if byte_cnt < RES_W/8-1: byte_cnt++, shift left by 8, go to TX_WAIT;
  - else, if idx < N*N-1: idx++, byte_cnt=0, go to RD;
  - else go to IDLE.
- Total bytes transmitted per job = N*N*RES_W/8.
- res_addr holds its last value outside RD/TX states.
- Async rst mid-job: immediate return to reset values. No partial TX byte is issued after reset release.

Test Plan:
- N=2, A bytes 1,2,3,4, B bytes 5,6,7,8 -> wr strobes A@0..3 then B@0..3 with matching data; one mult_start pulse; mat_n=2.
- Size byte 0, then size byte 9 (MAX_N=8) -> two err_size pulses; state stays IDLE; no wr_en; busy=0.
- After N=3, send 4 bytes, then stall TIMEOUT_CYC cycles -> err_timeout pulse; busy=0; next byte is parsed as a size byte.
- N=1, results 16'h1234 with mult_done held high; tx_busy model 10 cycles -> tx_data 8'h12 then 8'h34; exactly 2 tx_start pulses, each with tx_busy=0; then IDLE.
- N=2, tx_busy held high 50 cycles before each byte -> no tx_start while tx_busy=1; 8 bytes sent in address order 0..3.
- Assert rst during LOAD_B and during TX_WAIT -> all outputs at reset values; a fresh N=2 job afterwards completes correctly.
